// File: rtl/dilithium_adapter_pkg.sv
// Shared types, opcodes and output-length table for the Dilithium stream adapter.
package dilithium_adapter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StRun,
    StDone,
    StErr
  } state_e;

  localparam logic [3:0] OP_KEYGEN = 4'd1;
  localparam logic [3:0] OP_SIGN   = 4'd2;
  localparam logic [3:0] OP_VERIFY = 4'd3;

  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  // Output length in 32-bit external words, rows L2/L3/L5, columns keygen/sign/verify.
  localparam logic [15:0] OUT_WORDS [3][3] = '{
    '{16'd960,  16'd605,  16'd1},
    '{16'd1488, 16'd824,  16'd1},
    '{16'd1864, 16'd1149, 16'd1}
  };

  function automatic logic [1:0] sec_index(input int unsigned level);
    case (level)
      3:       return 2'd1;
      5:       return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [15:0] out_words(input int unsigned level, input logic [1:0] mode);
    if (mode == MODE_ILLEGAL) return 16'd0;
    return OUT_WORDS[sec_index(level)][mode];
  endfunction

  function automatic logic [3:0] op_code(input logic [1:0] mode);
    case (mode)
      2'd0:    return OP_KEYGEN;
      2'd1:    return OP_SIGN;
      2'd2:    return OP_VERIFY;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/dilithium_sync_fifo.sv
// Synchronous FIFO holding core result words until the unpacker drains them.
module dilithium_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush empties the buffer in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dilithium_stream_adapter.sv
// Bridges a narrow external stream to a wide Dilithium core: opcode issue,
// input lane packing, buffered result unpacking and output length tracking.
module dilithium_stream_adapter
  import dilithium_adapter_pkg::*;
#(
  parameter int unsigned SEC_LEVEL  = 2,
  parameter int unsigned EXT_W      = 32,
  parameter int unsigned CORE_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              valid_i,
  output logic              ready_i,
  input  logic [EXT_W-1:0]  data_i,
  output logic              valid_o,
  input  logic              ready_o,
  output logic [EXT_W-1:0]  data_o,
  output logic              done_o,
  output logic              err_o,
  output logic [3:0]        core_op_o,
  output logic              core_op_valid_o,
  input  logic              core_op_ready_i,
  output logic [CORE_W-1:0] core_in_data_o,
  output logic              core_in_valid_o,
  input  logic              core_in_ready_i,
  input  logic [CORE_W-1:0] core_out_data_i,
  input  logic              core_out_valid_i,
  output logic              core_out_ready_o
);

  localparam int unsigned RATIO = CORE_W / EXT_W;
  localparam int unsigned LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned CW    = $clog2(RATIO + 1);
  localparam logic [CW-1:0] FILL_FULL = CW'(RATIO);
  localparam logic [LW-1:0] LANE_LAST = LW'(RATIO - 1);

  state_e            state_q;
  logic [1:0]        mode_q;
  logic [3:0]        core_op_q;
  logic              core_op_valid_q, done_q, err_q;
  logic [15:0]       out_cnt_q;
  logic [LW-1:0]     out_lane_q;
  logic [CW-1:0]     fill_q;
  logic [CORE_W-1:0] pack_q;

  logic              run, start_ok, clear;
  logic              pack_full, pack_accept, in_hs, out_hs, last_word;
  logic [CW-1:0]     in_lane;
  logic [15:0]       target;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CORE_W-1:0] fifo_rdata;

  assign run         = (state_q == StRun);
  assign start_ok    = (state_q == StIdle) && start && (mode != MODE_ILLEGAL);
  assign clear       = start_ok || (state_q == StDone) || (state_q == StErr);
  assign pack_full   = (fill_q == FILL_FULL);
  assign pack_accept = core_in_valid_o && core_in_ready_i;
  assign in_hs       = valid_i && ready_i;
  // A lane arriving while the full word leaves restarts the packer at lane 0.
  assign in_lane     = pack_accept ? '0 : fill_q;

  assign ready_i          = run && !(pack_full && !core_in_ready_i);
  assign core_in_valid_o  = run && pack_full;
  assign core_in_data_o   = pack_q;
  assign core_out_ready_o = run && !fifo_full;
  assign fifo_push        = core_out_valid_i && core_out_ready_o;

  assign valid_o   = run && !fifo_empty;
  assign out_hs    = valid_o && ready_o;
  assign target    = out_words(SEC_LEVEL, mode_q);
  assign last_word = out_hs && ((out_cnt_q + 16'd1) == target);
  // The final word of an operation drops whatever lanes remain in the head.
  assign fifo_pop  = out_hs && ((out_lane_q == LANE_LAST) || last_word);

  assign core_op_o       = core_op_q;
  assign core_op_valid_o = core_op_valid_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

  // Select the current lane of the FIFO head; zero when nothing is presented.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (valid_o && (out_lane_q == LW'(k))) data_o = fifo_rdata[k*EXT_W +: EXT_W];
    end
  end

  // Control FSM with registered opcode and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      mode_q          <= 2'd0;
      core_op_q       <= 4'd0;
      core_op_valid_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (mode == MODE_ILLEGAL) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              mode_q          <= mode;
              core_op_q       <= op_code(mode);
              core_op_valid_q <= 1'b1;
              state_q         <= StIssue;
            end
          end
        end
        StIssue: begin
          if (core_op_ready_i) begin
            core_op_q       <= 4'd0;
            core_op_valid_q <= 1'b0;
            state_q         <= StRun;
          end
        end
        StRun: begin
          if (last_word) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Packer fill state, unpacker lane pointer and output word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q  <= '0;
      out_lane_q <= '0;
      fill_q     <= '0;
      pack_q     <= '0;
    end else if (clear) begin
      out_cnt_q  <= '0;
      out_lane_q <= '0;
      fill_q     <= '0;
      pack_q     <= '0;
    end else begin
      if (out_hs) begin
        out_cnt_q  <= out_cnt_q + 16'd1;
        out_lane_q <= fifo_pop ? '0 : out_lane_q + 1'b1;
      end
      if (pack_accept) fill_q <= in_hs ? CW'(1) : '0;
      else if (in_hs)  fill_q <= fill_q + CW'(1);
      if (in_hs) begin
        for (int k = 0; k < RATIO; k++) begin
          if (in_lane == CW'(k)) pack_q[k*EXT_W +: EXT_W] <= data_i;
        end
      end
    end
  end

  dilithium_sync_fifo #(
    .WIDTH (CORE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (clear),
    .wr_en   (fifo_push),
    .wr_data (core_out_data_i),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_dilithium_stream_adapter.sv
// Self-checking bench for dilithium_stream_adapter: directed scenarios plus
// randomized full operations checked against a lane-queue reference model.
module tb_dilithium_stream_adapter;
  import dilithium_adapter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        valid_i, ready_i;
  logic [31:0] data_i;
  logic        valid_o, ready_o;
  logic [31:0] data_o;
  logic        done_o, err_o;
  logic [3:0]  core_op_o;
  logic        core_op_valid_o, core_op_ready_i;
  logic [63:0] core_in_data_o;
  logic        core_in_valid_o, core_in_ready_i;
  logic [63:0] core_out_data_i;
  logic        core_out_valid_i, core_out_ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  dilithium_stream_adapter #(
    .SEC_LEVEL  (2),
    .EXT_W      (32),
    .CORE_W     (64),
    .FIFO_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mode             (mode),
    .valid_i          (valid_i),
    .ready_i          (ready_i),
    .data_i           (data_i),
    .valid_o          (valid_o),
    .ready_o          (ready_o),
    .data_o           (data_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .core_op_o        (core_op_o),
    .core_op_valid_o  (core_op_valid_o),
    .core_op_ready_i  (core_op_ready_i),
    .core_in_data_o   (core_in_data_o),
    .core_in_valid_o  (core_in_valid_o),
    .core_in_ready_i  (core_in_ready_i),
    .core_out_data_i  (core_out_data_i),
    .core_out_valid_i (core_out_valid_i),
    .core_out_ready_o (core_out_ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ready_i"},          64'(ready_i),          64'd0);
    check({pfx, "_valid_o"},          64'(valid_o),          64'd0);
    check({pfx, "_data_o"},           64'(data_o),           64'd0);
    check({pfx, "_done_o"},           64'(done_o),           64'd0);
    check({pfx, "_err_o"},            64'(err_o),            64'd0);
    check({pfx, "_core_op_o"},        64'(core_op_o),        64'd0);
    check({pfx, "_core_op_valid_o"},  64'(core_op_valid_o),  64'd0);
    check({pfx, "_core_in_valid_o"},  64'(core_in_valid_o),  64'd0);
    check({pfx, "_core_in_data_o"},   core_in_data_o,        64'd0);
    check({pfx, "_core_out_ready_o"}, 64'(core_out_ready_o), 64'd0);
    check({pfx, "_state"},            64'(dut.state_q),      64'(StIdle));
  endtask

  task automatic quiet_inputs();
    start            = 1'b0;
    mode             = 2'd0;
    valid_i          = 1'b0;
    data_i           = 32'd0;
    ready_o          = 1'b0;
    core_op_ready_i  = 1'b0;
    core_in_ready_i  = 1'b0;
    core_out_data_i  = 64'd0;
    core_out_valid_i = 1'b0;
  endtask

  // Full randomized operation. Reference: output stream is the core result
  // words split into 32-bit lanes (low lane first), truncated to the table
  // length; each packed core input word is two consecutive accepted inputs.
  task automatic run_op(input logic [1:0] m, input bit bp);
    int          n_exp;
    int          got;
    int          acc;
    bit          fin;
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    logic [31:0] lo, hi, exp_w;
    n_exp = (m == 2'd0) ? 960 : (m == 2'd1) ? 605 : 1;
    got = 0;
    acc = 0;
    fin = 1'b0;
    @(negedge clk);
    mode = m;
    start = 1'b1;
    core_op_ready_i = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    core_op_ready_i = 1'b0;
    check("op_run_state", 64'(dut.state_q), 64'(StRun));
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      if (bp && cyc == 10) begin
        check("bp_words_accepted", 64'(acc), 64'd4);
        check("bp_core_out_ready", 64'(core_out_ready_o), 64'd0);
      end
      valid_i         = 1'($urandom_range(0, 1));
      data_i          = $urandom;
      core_in_ready_i = 1'($urandom_range(0, 1));
      core_out_data_i = {$urandom, $urandom};
      if (bp && cyc < 10) begin
        ready_o          = 1'b0;
        core_out_valid_i = 1'b1;
      end else begin
        ready_o          = ($urandom_range(0, 3) != 0);
        core_out_valid_i = 1'($urandom_range(0, 1));
      end
      #1;
      check("done_early", 64'(done_o), 64'd0);
      if (core_in_valid_o && core_in_ready_i) begin
        check("pack_depth", 64'(in_q.size()), 64'd2);
        if (in_q.size() >= 2) begin
          lo = in_q.pop_front();
          hi = in_q.pop_front();
          check("pack_word", core_in_data_o, {hi, lo});
        end
      end
      if (valid_i && ready_i) in_q.push_back(data_i);
      if (core_out_valid_i && core_out_ready_o) begin
        out_q.push_back(core_out_data_i[31:0]);
        out_q.push_back(core_out_data_i[63:32]);
        acc++;
      end
      if (valid_o && ready_o) begin
        exp_w = (out_q.size() > 0) ? out_q.pop_front() : 32'hxxxx_xxxx;
        check("out_word", 64'(data_o), 64'(exp_w));
        got++;
        if (got == n_exp) fin = 1'b1;
      end
      @(negedge clk);
    end
    if (!fin) check("op_timeout", 64'(got), 64'(n_exp));
    quiet_inputs();
    #1;
    check("op_done_pulse", 64'(done_o), 64'd1);
    check("op_done_state", 64'(dut.state_q), 64'(StDone));
    check("op_done_valid_o", 64'(valid_o), 64'd0);
    @(negedge clk);
    check("op_done_clear", 64'(done_o), 64'd0);
    check("op_idle_state", 64'(dut.state_q), 64'(StIdle));
  endtask

  initial begin
    quiet_inputs();
    rst = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Opcode issue held across three stalled cycles.
    @(negedge clk);
    mode = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("issue_op", 64'(core_op_o), 64'd3);
      check("issue_valid", 64'(core_op_valid_o), 64'd1);
      if (i == 3) core_op_ready_i = 1'b1;
      @(negedge clk);
    end
    core_op_ready_i = 1'b0;
    #1;
    check("issue_run_state", 64'(dut.state_q), 64'(StRun));
    check("issue_valid_drop", 64'(core_op_valid_o), 64'd0);

    // Two lanes pack into one core word, low lane first.
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = 32'h1111_1111;
    @(negedge clk);
    data_i  = 32'h2222_2222;
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check("pack_data", core_in_data_o, 64'h2222_2222_1111_1111);
    check("pack_valid", 64'(core_in_valid_o), 64'd1);
    check("pack_stall_ready_i", 64'(ready_i), 64'd0);
    core_in_ready_i = 1'b1;
    #1;
    check("pack_zero_bubble_ready_i", 64'(ready_i), 64'd1);
    @(negedge clk);
    core_in_ready_i = 1'b0;
    #1;
    check("pack_drained", 64'(core_in_valid_o), 64'd0);

    // Verify result: one word out, upper lane discarded.
    core_out_data_i  = 64'h0000_0005_0000_0001;
    core_out_valid_i = 1'b1;
    @(negedge clk);
    core_out_valid_i = 1'b0;
    #1;
    check("verify_valid_o", 64'(valid_o), 64'd1);
    check("verify_data_o", 64'(data_o), 64'd1);
    ready_o = 1'b1;
    @(negedge clk);
    ready_o = 1'b0;
    #1;
    check("verify_done", 64'(done_o), 64'd1);
    check("verify_no_upper", 64'(valid_o), 64'd0);
    @(negedge clk);
    #1;
    check("verify_done_once", 64'(done_o), 64'd0);
    check("verify_idle", 64'(dut.state_q), 64'(StIdle));
    check("verify_flushed", 64'(dut.fifo_empty), 64'd1);

    // Illegal mode.
    @(negedge clk);
    mode = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("illegal_err", 64'(err_o), 64'd1);
    check("illegal_no_op", 64'(core_op_valid_o), 64'd0);
    @(negedge clk);
    #1;
    check("illegal_err_once", 64'(err_o), 64'd0);
    check("illegal_idle", 64'(dut.state_q), 64'(StIdle));
    check("illegal_no_op2", 64'(core_op_valid_o), 64'd0);

    // Randomized operations; sign starts under output backpressure.
    run_op(2'd1, 1'b1);
    run_op(2'd2, 1'b0);
    run_op(2'd0, 1'b0);

    // Reset in the middle of a keygen run.
    @(negedge clk);
    mode = 2'd0;
    start = 1'b1;
    core_op_ready_i = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    core_op_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_i          = 1'b1;
      data_i           = $urandom;
      core_out_valid_i = 1'b1;
      core_out_data_i  = {$urandom, $urandom};
      @(negedge clk);
    end
    check("midrun_state", 64'(dut.state_q), 64'(StRun));
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    check("midrun_fifo_empty", 64'(dut.fifo_empty), 64'd1);
    quiet_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrun_no_done", 64'(done_o), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
